// File: rtl/fetch_queue.sv
// fetch_queue: fetch-PC owner and pair FIFO between the fetch stage and decode
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   fetch_pc               PC of the pair requested this cycle (pc, pc+4)
//   fd_reg                 pair returned by the fetch stage, one cycle after the request
//   flush, redirect_pc     discard everything buffered/in flight and restart at redirect_pc
//   dec_valid, dec_ready   head-of-queue handshake toward decode
//   dec_inst_a/b, dec_pc_a/b  head pair contents, zero when empty
//   full, prog_done        queue full; fetch parked past end of IROM and fully drained
package fetch_pkg;
  typedef struct packed {
    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
  } fetch_t;
endpackage

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IMEM_BYTES = 128,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fetch_pc,
  input  fetch_t      fd_reg,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst_a,
  output logic [31:0] dec_inst_b,
  output logic [31:0] dec_pc_a,
  output logic [31:0] dec_pc_b,
  output logic        full,
  output logic        prog_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_t mem [DEPTH];
  fetch_t head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [32:0] pair_end;
  logic req_q, has_pair, issue, push, pop;
  // 33-bit sum so a PC near the top of the address space cannot wrap into range
  assign pair_end = {1'b0, fetch_pc} + 33'd4;
  assign has_pair = pair_end < 33'(IMEM_BYTES);
  // credit counts the in-flight pair; a same-cycle pop earns no credit
  assign occ = {1'b0, count} + (CW+1)'(req_q);
  assign issue = !flush && has_pair && (occ < (CW+1)'(DEPTH));
  assign push = req_q && !flush;
  assign pop = dec_valid && dec_ready && !flush;
  assign dec_valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign prog_done = !has_pair && !req_q && !dec_valid;
  assign head = mem[rd_ptr];
  assign dec_inst_a = dec_valid ? head.inst_a : '0;
  assign dec_inst_b = dec_valid ? head.inst_b : '0;
  assign dec_pc_a = dec_valid ? head.pc_a : '0;
  assign dec_pc_b = dec_valid ? head.pc_b : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      fetch_pc <= redirect_pc;
      req_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd8;
      req_q <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fd_reg;
  end
endmodule
